csa_accum_seq: RTL and testbench



---
 rtl/csa_accum_seq.sv | 82 ++++++++
 tb/tb_csa_accum_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/csa_accum_seq.sv
// csa_accum_seq: carry-save multi-operand accumulator with one final carry-propagate add.
// Define CSA_ACCUM_SIGNED_EN for sign-extended operands; otherwise operands are zero-extended.
module csa_accum_seq #(
   parameter int OP_WIDTH  = 32,
   parameter int ACC_WIDTH = OP_WIDTH + 8,
   parameter int MAX_OPS   = 255,
   parameter int CNT_WIDTH = $clog2(MAX_OPS + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [CNT_WIDTH-1:0] num_ops_i,
   input  logic                 op_valid_i,
   output logic                 op_ready_o,
   input  logic [OP_WIDTH-1:0]  op_i,
   output logic                 res_valid_o,
   input  logic                 res_ready_i,
   output logic [ACC_WIDTH-1:0] res_o,
   output logic                 busy_o
);
   typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;
   state_t state;
   logic [ACC_WIDTH-1:0] s, c, x, s_nxt, c_nxt;
   logic [CNT_WIDTH-1:0] rem;
`ifdef CSA_ACCUM_SIGNED_EN
   assign x = {{(ACC_WIDTH-OP_WIDTH){op_i[OP_WIDTH-1]}}, op_i};
`else
   assign x = {{(ACC_WIDTH-OP_WIDTH){1'b0}}, op_i};
`endif
   // 3:2 compression: no carry ripples until RESOLVE
   assign s_nxt = s ^ c ^ x;
   assign c_nxt = ((s & c) | (s & x) | (c & x)) << 1;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         s           <= '0;
         c           <= '0;
         rem         <= '0;
         op_ready_o  <= 1'b0;
         res_valid_o <= 1'b0;
         res_o       <= '0;
         busy_o      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               s <= '0;
               c <= '0;
               if (start_i) begin
                  rem    <= num_ops_i;
                  busy_o <= 1'b1;
                  if (num_ops_i != '0) begin
                     state      <= ACCUM;
                     op_ready_o <= 1'b1;
                  end else state <= RESOLVE;
               end
            end
            ACCUM: if (op_valid_i && op_ready_o) begin
               s   <= s_nxt;
               c   <= c_nxt;
               rem <= rem - 1'b1;
               if (rem == CNT_WIDTH'(1)) begin
                  state      <= RESOLVE;
                  op_ready_o <= 1'b0;
               end
            end
            RESOLVE: begin
               res_o       <= s + c;
               res_valid_o <= 1'b1;
               state       <= DONE;
            end
            DONE: if (res_ready_i) begin
               s           <= '0;
               c           <= '0;
               res_valid_o <= 1'b0;
               busy_o      <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_csa_accum_seq.sv
// tb_csa_accum_seq: randomized bench for csa_accum_seq against a plain-arithmetic sum model.
module tb_csa_accum_seq;
   logic        clk_i = 1'b0, rst_i = 1'b1;
   logic        start = 1'b0, op_valid = 1'b0, res_ready = 1'b0;
   logic [7:0]  num_ops = '0;
   logic [31:0] op = '0;
   logic        op_ready, res_valid, busy;
   logic [39:0] res;
   logic        start8 = 1'b0, valid8 = 1'b0, rr8 = 1'b0;
   logic [7:0]  num8 = '0, op8 = '0;
   logic        ready8, rv8, busy8;
   logic [8:0]  res8;
   int n_cmp = 0, n_err = 0;

   always #5 clk_i = ~clk_i;

   csa_accum_seq dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start), .num_ops_i(num_ops),
      .op_valid_i(op_valid), .op_ready_o(op_ready), .op_i(op),
      .res_valid_o(res_valid), .res_ready_i(res_ready), .res_o(res), .busy_o(busy));

   csa_accum_seq #(.OP_WIDTH(8), .ACC_WIDTH(9)) dut8 (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start8), .num_ops_i(num8),
      .op_valid_i(valid8), .op_ready_o(ready8), .op_i(op8),
      .res_valid_o(rv8), .res_ready_i(rr8), .res_o(res8), .busy_o(busy8));

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [39:0] model_sum(input logic [31:0] ops[$]);
      logic [39:0] acc = '0;
      foreach (ops[i]) begin
`ifdef CSA_ACCUM_SIGNED_EN
         acc = acc + {{8{ops[i][31]}}, ops[i]};
`else
         acc = acc + {8'h00, ops[i]};
`endif
      end
      return acc;
   endfunction

   // Drives one job; lat is the clock edge (counted from the start edge) at which res_valid is first sampled high.
   task automatic run_job(input int n, input logic [31:0] ops[$], input int bubble_pct, input int stall,
                          input bit noisy_start, output logic [39:0] r, output int lat, output bit stable,
                          output bit ready_seen, output bit timeout, output int accepted);
      int k = 0, idx = 0;
      bit hs;
      logic [39:0] held;
      stable = 1; ready_seen = 0; timeout = 0; accepted = 0;
      start = 1; num_ops = n[7:0];
      step();
      start = 0;
      while (!res_valid && k < 2000) begin
         if (op_ready) ready_seen = 1;
         if (idx < ops.size() && $urandom_range(99) >= bubble_pct) begin
            op_valid = 1; op = ops[idx];
         end else begin
            op_valid = 0; op = $urandom;
         end
         start = noisy_start ? 1'($urandom_range(1)) : 1'b0;
         num_ops = 8'($urandom);
         hs = op_valid && op_ready;
         step();
         k++;
         if (hs) begin idx++; accepted++; end
      end
      op_valid = 0;
      if (op_ready) ready_seen = 1;
      timeout = !res_valid;
      lat = k + 1;
      r = res;
      held = res;
      repeat (stall) begin
         start = noisy_start ? 1'($urandom_range(1)) : 1'b0;
         step();
         if (!res_valid || res !== held) stable = 0;
      end
      start = 0;
      res_ready = 1;
      step();
      res_ready = 0;
   endtask

   task automatic test_reset();
      rst_i = 1;
      repeat (2) step();
      n_cmp++; if (op_ready !== 1'b0) begin n_err++; $display("FAIL reset_op_ready got %0b want 0", op_ready); end
      n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid got %0b want 0", res_valid); end
      n_cmp++; if (res !== 40'd0) begin n_err++; $display("FAIL reset_res got %0h want 0", res); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
      rst_i = 0;
      step();
   endtask

   task automatic test_basic();
      logic [31:0] q[$] = '{32'd1, 32'd2, 32'd3};
      logic [39:0] r; int lat, acc; bit st, rs, to;
      run_job(3, q, 0, 0, 0, r, lat, st, rs, to, acc);
      n_cmp++; if (to) begin n_err++; $display("FAIL basic_timeout got no res_valid want res_valid"); end
      n_cmp++; if (r !== 40'd6) begin n_err++; $display("FAIL basic_sum got %0d want 6", r); end
      n_cmp++; if (lat != 5) begin n_err++; $display("FAIL basic_latency got %0d want 5", lat); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle_busy got %0b want 0", busy); end
   endtask

   task automatic test_bubbles();
      logic [31:0] q[$] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [39:0] r, want; int lat, acc; bit st, rs, to;
`ifdef CSA_ACCUM_SIGNED_EN
      want = 40'hFF_FFFF_FFFC;
`else
      want = 40'h03_FFFF_FFFC;
`endif
      run_job(4, q, 50, 3, 0, r, lat, st, rs, to, acc);
      n_cmp++; if (r !== want) begin n_err++; $display("FAIL bubble_sum got %0h want %0h", r, want); end
      n_cmp++; if (r !== model_sum(q)) begin n_err++; $display("FAIL bubble_model got %0h want %0h", r, model_sum(q)); end
      n_cmp++; if (!st) begin n_err++; $display("FAIL bubble_stable got unstable want stable"); end
      n_cmp++; if (acc != 4) begin n_err++; $display("FAIL bubble_accepted got %0d want 4", acc); end
   endtask

   task automatic test_wrap();
      int ops[3] = '{255, 255, 3};
      int k = 0, want;
`ifdef CSA_ACCUM_SIGNED_EN
      want = (-1 - 1 + 3 + 512) % 512;
`else
      want = (255 + 255 + 3) % 512;
`endif
      start8 = 1; num8 = 8'd3;
      step();
      start8 = 0; valid8 = 1;
      foreach (ops[i]) begin op8 = 8'(ops[i]); step(); end
      valid8 = 0;
      while (!rv8 && k < 20) begin step(); k++; end
      n_cmp++; if (res8 !== 9'(want) || !rv8) begin n_err++; $display("FAIL wrap_sum got %0d (valid %0b) want %0d", res8, rv8, want); end
      rr8 = 1; step(); rr8 = 0;
      n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL wrap_idle_busy got %0b want 0", busy8); end
   endtask

   task automatic test_zero_ops();
      logic [31:0] q[$];
      logic [39:0] r; int lat, acc; bit st, rs, to;
      run_job(0, q, 0, 1, 0, r, lat, st, rs, to, acc);
      n_cmp++; if (r !== 40'd0) begin n_err++; $display("FAIL zero_sum got %0h want 0", r); end
      n_cmp++; if (lat != 2) begin n_err++; $display("FAIL zero_latency got %0d want 2", lat); end
      n_cmp++; if (rs) begin n_err++; $display("FAIL zero_op_ready got seen-high want never-high"); end
   endtask

   task automatic test_reset_midjob();
      logic [31:0] q[$] = '{32'd7, 32'd8};
      logic [39:0] r; int lat, acc; bit st, rs, to;
      start = 1; num_ops = 8'd5;
      step();
      start = 0; op_valid = 1;
      op = 32'd1000; step();
      op = 32'd2000; step();
      op_valid = 0; rst_i = 1;
      step();
      n_cmp++; if (op_ready !== 1'b0) begin n_err++; $display("FAIL midrst_op_ready got %0b want 0", op_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %0b want 0", busy); end
      n_cmp++; if (res !== 40'd0) begin n_err++; $display("FAIL midrst_res got %0h want 0", res); end
      n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL midrst_res_valid got %0b want 0", res_valid); end
      rst_i = 0;
      step();
      run_job(2, q, 0, 0, 0, r, lat, st, rs, to, acc);
      n_cmp++; if (r !== 40'd15) begin n_err++; $display("FAIL midrst_fresh_sum got %0d want 15", r); end
      n_cmp++; if (lat != 4) begin n_err++; $display("FAIL midrst_latency got %0d want 4", lat); end
   endtask

   task automatic test_random_start_noise();
      for (int j = 0; j < 8; j++) begin
         logic [31:0] q[$];
         logic [39:0] r; int lat, acc, n; bit st, rs, to;
         n = $urandom_range(1, 24);
         for (int i = 0; i < n; i++) q.push_back($urandom);
         run_job(n, q, 30, $urandom_range(0, 3), 1, r, lat, st, rs, to, acc);
         n_cmp++; if (r !== model_sum(q)) begin n_err++; $display("FAIL rand_sum[%0d] got %0h want %0h", j, r, model_sum(q)); end
         n_cmp++; if (acc != n) begin n_err++; $display("FAIL rand_count[%0d] got %0d want %0d", j, acc, n); end
         n_cmp++; if (!st || to) begin n_err++; $display("FAIL rand_stable[%0d] got stable=%0b timeout=%0b want 1/0", j, st, to); end
         n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rand_idle[%0d] got busy %0b want 0", j, busy); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bubbles();
      test_wrap();
      test_zero_ops();
      test_reset_midjob();
      test_random_start_noise();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
